// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, 7-bit address, R/W, ACK, one data byte, STOP.
// Optional I2C_MASTER_ACK_CHECK_EN: a NACKed address skips DATA and raises ack_err.
module i2c_master_ctrl #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   input  logic       sda_in,
   output logic       i2c_scl,
   output logic       i2c_sda,
   output logic       m_stop,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       ack_err
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      ADDR  = 3'd2,
      RW    = 3'd3,
      ACK   = 3'd4,
      DATA  = 3'd5,
      STOP  = 3'd6
   } state_t;

   state_t        state, state_nxt;
   logic          half, half_nxt;      // 0 = scl-low half, 1 = scl-high half
   logic [2:0]    bit_idx, bit_nxt;
   logic [DW-1:0] div;
   logic          tick;
   logic          ack_fail;
   logic [6:0]    addr_q;
   logic          rw_q;
   logic [7:0]    wdata_q;
   logic [7:0]    shift_q;
   logic          last_half;

   assign tick      = (state != IDLE) && (div == DW'(CLK_DIV - 1));
   assign last_half = tick && half;

`ifdef I2C_MASTER_ACK_CHECK_EN
   logic nack_q;
   logic ack_err_q;
   assign ack_fail = ~sda_in;
   assign ack_err  = ack_err_q;
`else
   assign ack_fail = 1'b0;
   assign ack_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         half    <= 1'b0;
         bit_idx <= 3'd0;
      end else begin
         state   <= state_nxt;
         half    <= half_nxt;
         bit_idx <= bit_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      half_nxt  = half;
      bit_nxt   = bit_idx;
      i2c_scl   = 1'b1;
      i2c_sda   = 1'b1;
      m_stop    = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = START;
               half_nxt  = 1'b0;
            end
         end
         START: begin
            i2c_sda = 1'b0;
            if (tick) begin
               state_nxt = ADDR;
               half_nxt  = 1'b0;
               bit_nxt   = 3'd6;
            end
         end
         ADDR: begin
            i2c_scl = half;
            i2c_sda = addr_q[bit_idx];
            if (tick) begin
               half_nxt = ~half;
               if (half) begin
                  if (bit_idx == 3'd0) state_nxt = RW;
                  else                 bit_nxt   = bit_idx - 3'd1;
               end
            end
         end
         RW: begin
            i2c_scl = half;
            i2c_sda = rw_q;
            if (tick) begin
               half_nxt = ~half;
               if (half) state_nxt = ACK;
            end
         end
         ACK: begin
            i2c_scl = half;
            if (tick) begin
               half_nxt = ~half;
               if (half) begin
                  state_nxt = ack_fail ? STOP : DATA;
                  bit_nxt   = 3'd7;
               end
            end
         end
         DATA: begin
            i2c_scl = half;
            i2c_sda = rw_q ? 1'b1 : wdata_q[bit_idx];
            if (tick) begin
               half_nxt = ~half;
               if (half) begin
                  if (bit_idx == 3'd0) state_nxt = STOP;
                  else                 bit_nxt   = bit_idx - 3'd1;
               end
            end
         end
         STOP: begin
            i2c_scl = half;
            i2c_sda = 1'b0;
            m_stop  = half;
            if (tick) begin
               half_nxt = ~half;
               if (half) state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            half_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div     <= '0;
         done    <= 1'b0;
         rdata   <= 8'h00;
         addr_q  <= 7'h00;
         rw_q    <= 1'b0;
         wdata_q <= 8'h00;
         shift_q <= 8'h00;
`ifdef I2C_MASTER_ACK_CHECK_EN
         nack_q    <= 1'b0;
         ack_err_q <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            div <= '0;
            if (start) begin
               addr_q  <= addr;
               rw_q    <= rw;
               wdata_q <= wdata;
            end
         end else begin
            div <= tick ? '0 : div + DW'(1);
         end

         if (last_half && state == DATA && rw_q)
            shift_q <= {shift_q[6:0], sda_in};

`ifdef I2C_MASTER_ACK_CHECK_EN
         if (last_half && state == ACK)
            nack_q <= ~sda_in;
         if (last_half && state == STOP) begin
            done      <= 1'b1;
            ack_err_q <= nack_q;
            if (rw_q && !nack_q) rdata <= shift_q;
         end
`else
         if (last_half && state == STOP) begin
            done <= 1'b1;
            if (rw_q) rdata <= shift_q;
         end
`endif
      end
   end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a behavioural slave decodes SCL/SDA and a transaction-level model
// predicts busy length, bit content, rdata and ack_err.
module tb_i2c_master_ctrl;

   localparam int CD = 4;
`ifdef I2C_MASTER_ACK_CHECK_EN
   localparam bit ACK_CHK = 1'b1;
`else
   localparam bit ACK_CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, start, rw;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       sda_in = 1'b1;
   logic       i2c_scl, i2c_sda, m_stop, busy, done, ack_err;
   logic [7:0] rdata;

   i2c_master_ctrl #(.CLK_DIV(CD)) dut (
      .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
      .sda_in(sda_in), .i2c_scl(i2c_scl), .i2c_sda(i2c_sda), .m_stop(m_stop),
      .busy(busy), .done(done), .rdata(rdata), .ack_err(ack_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // transaction model and slave stimulus
   logic [6:0] exp_addr;
   logic [7:0] exp_wdata;
   logic [7:0] mdl_rdata;
   bit         exp_rw, exp_nack;
   bit         slv_ack;
   logic [7:0] slv_rbyte;

   // behavioural slave: bit k starts at the k-th SCL fall after START
   int   bitno     = -1;
   logic prev_scl  = 1'b1;
   logic prev_busy = 1'b0;
   logic cap [0:31];

   always @(negedge clk) begin
      if (busy && !prev_busy) begin
         bitno = -1;
         for (int i = 0; i < 32; i++) cap[i] = 1'b0;
      end
      if (busy) begin
         if (prev_scl && !i2c_scl) begin
            bitno++;
            if (bitno == 8)                              sda_in = slv_ack;
            else if (bitno >= 9 && bitno <= 16 && exp_rw) sda_in = slv_rbyte[16 - bitno];
            else                                         sda_in = 1'($urandom_range(1, 0));
         end
         if (!prev_scl && i2c_scl && bitno >= 0 && bitno < 32) cap[bitno] = i2c_sda;
      end
      prev_scl  = i2c_scl;
      prev_busy = busy;
   end

   task automatic start_txn(input logic [6:0] a, input bit r, input logic [7:0] w,
                            input bit ackv, input logic [7:0] rb, input bit hold);
      @(negedge clk);
      addr = a; rw = r; wdata = w; start = 1'b1;
      slv_ack = ackv; slv_rbyte = rb;
      exp_addr = a; exp_rw = r; exp_wdata = w;
      exp_nack = ACK_CHK && !ackv;
      @(negedge clk);
      check("busy_on_start", busy, 1);
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_txn(input bit hold);
      int         bc = 1;
      int         mc = 0;
      bit         seen = 1'b0;
      logic [6:0] a_cap;
      logic [7:0] d_cap;
      for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
         if (!hold && cyc < 8) begin
            start = 1'($urandom_range(1, 0));
            addr  = 7'($urandom);
            wdata = 8'($urandom);
            rw    = 1'($urandom_range(1, 0));
         end else if (!hold) begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            if (busy)   bc++;
            if (m_stop) mc++;
         end
      end
      check("done_seen", seen, 1);
      check("busy_cycles", bc, exp_nack ? 21*CD : 37*CD);
      check("mstop_cycles", mc, CD);
      check("scl_at_done", i2c_scl, 1);
      check("sda_at_done", i2c_sda, 1);
      check("mstop_at_done", m_stop, 0);
      check("busy_at_done", busy, 0);
      check("scl_falls", bitno + 1, exp_nack ? 10 : 18);
      for (int i = 0; i < 7; i++) a_cap[6 - i] = cap[i];
      check("addr_bits", a_cap, exp_addr);
      check("rw_bit", cap[7], exp_rw);
      check("ack_released", cap[8], 1);
      if (!exp_nack) begin
         for (int i = 0; i < 8; i++) d_cap[7 - i] = cap[9 + i];
         check("data_bits", d_cap, exp_rw ? 8'hFF : exp_wdata);
      end
      if (exp_rw && !exp_nack) mdl_rdata = slv_rbyte;
      check("rdata", rdata, mdl_rdata);
      check("ack_err", ack_err, exp_nack);
      if (!hold) begin
         @(negedge clk);
         check("done_one_cycle", done, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ok;
      bit         flag;
      logic [6:0] a;
      reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
      slv_ack = 1'b1; slv_rbyte = 8'h00; mdl_rdata = 8'h00;
      exp_addr = 7'h00; exp_wdata = 8'h00; exp_rw = 1'b0; exp_nack = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_scl", i2c_scl, 1);
      check("rst_sda", i2c_sda, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_ack_err", ack_err, 0);

      start_txn(7'h54, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0); wait_txn(1'b0);
      start_txn(7'h54, 1'b1, 8'h00, 1'b1, 8'h3C, 1'b0); wait_txn(1'b0);
      start_txn(7'h12, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0); wait_txn(1'b0);
      start_txn(7'h12, 1'b1, 8'h00, 1'b0, 8'hE1, 1'b0); wait_txn(1'b0);
      start_txn(7'h54, 1'b0, 8'h0F, 1'b1, 8'h00, 1'b0); wait_txn(1'b0);

      for (int k = 0; k < 20; k++) begin
         a = 7'($urandom);
         start_txn(a, 1'($urandom_range(1, 0)), 8'($urandom),
                   ($urandom_range(3, 0) != 0), 8'($urandom), 1'b0);
         wait_txn(1'b0);
      end

      // start held through done: the next transaction begins right after the done cycle
      start_txn(7'h2B, 1'b1, 8'h00, 1'b1, 8'h96, 1'b1);
      wait_txn(1'b1);
      @(negedge clk);
      check("hold_restart_busy", busy, 1);
      check("hold_restart_done", done, 0);
      start = 1'b0;
      wait_txn(1'b1);
      @(negedge clk);
      check("hold_done_one_cycle", done, 0);

      // reset while DATA bit 3 is on the wire
      start_txn(7'h54, 1'b0, 8'hC3, 1'b1, 8'h00, 1'b0);
      ok = 1'b0;
      for (int cyc = 0; cyc < 2000 && !ok; cyc++) begin
         @(negedge clk);
         if (busy && bitno == 13 && i2c_scl) ok = 1'b1;
      end
      check("reach_data_bit3", ok, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mdl_rdata = 8'h00;
      check("mid_rst_scl", i2c_scl, 1);
      check("mid_rst_sda", i2c_sda, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_mstop", m_stop, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_rdata", rdata, mdl_rdata);
      check("mid_rst_ack_err", ack_err, 0);
      flag = 1'b0;
      repeat (3*CD) begin
         @(negedge clk);
         if (done || busy || m_stop) flag = 1'b1;
      end
      check("no_stop_after_rst", flag, 0);

      start_txn(7'h54, 1'b1, 8'h00, 1'b1, 8'h5A, 1'b0); wait_txn(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 CLK_DIV, 4, system-clock cycles per SCL half-period; legal values are 2 or more.
REQ-002 clk  in  1  system clock; the only clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  transaction request, sampled only in IDLE.
REQ-005 rw  in  1  request direction: 0 = write to slave, 1 = read from slave.
REQ-006 addr  in  7  target slave address, sent MSB first.
REQ-007 wdata  in  8  write byte, sent MSB first.
REQ-008 sda_in  in  1  SDA driven by the slave (the slave's sda_out).
REQ-009 i2c_scl  out  1  SCL to the slave.
REQ-010 i2c_sda  out  1  SDA from master to slave.
REQ-011 m_stop  out  1  stop indicator to the slave.
REQ-012 busy  out  1  transaction in progress.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 rdata  out  8  last byte read.
REQ-015 ack_err  out  1  address not acknowledged in the last transaction.

Function
REQ-016 Divider counter SHALL run 0..CLK_DIV-1 only while busy=1; each wrap SHALL be a tick, and every phase change SHALL occur on a tick.
REQ-017 States SHALL be IDLE, START, ADDR, RW, ACK, DATA, STOP.
REQ-018 IDLE SHALL hold i2c_scl=1, i2c_sda=1, m_stop=0, busy=0.
REQ-019 In IDLE, start=1 SHALL latch addr, rw and wdata, then enter START with busy=1 on the next cycle.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 START SHALL last one half-period with scl=1 and sda=0.
REQ-022 Every bit SHALL take two half-periods: scl=0 with sda updated at its start, then scl=1 with sda stable.
REQ-023 ADDR SHALL send addr[6] down to addr[0]; RW SHALL then send the latched rw.
REQ-024 ACK SHALL drive sda=1 (released) and sample sda_in on the last clk of its scl-high half; sda_in=1 means acknowledge (the slave drives 1 on address match).
REQ-025 DATA write SHALL send wdata[7] down to wdata[0].
REQ-026 DATA read SHALL drive sda=1 and shift sda_in into rdata MSB first, sampled on the last clk of each scl-high half.
REQ-027 rdata SHALL update only on read completion and hold otherwise.
REQ-028 STOP SHALL be a scl=0/sda=0 half-period, then a scl=1/sda=0 half-period with m_stop=1.
REQ-029 At the end of STOP, in the same edge: sda=1, m_stop=0, busy=0, done=1 for one cycle, state=IDLE.
REQ-030 A successful transaction SHALL keep busy=1 for exactly 37*CLK_DIV cycles.
REQ-031 A start sampled in the cycle done=1 SHALL be accepted, since state is IDLE in that cycle.

Reset
REQ-032 reset=1 SHALL, at the next clk edge regardless of state, set: state=IDLE, i2c_scl=1, i2c_sda=1, m_stop=0, busy=0, done=0, rdata=0, ack_err=0, divider=0.
REQ-033 A reset mid-transaction SHALL abort without generating STOP.
REQ-034 reset SHALL take priority over start.

Configuration
REQ-035 Macro I2C_MASTER_ACK_CHECK_EN defined: sda_in=0 in ACK SHALL skip DATA and go to STOP, with ack_err=1 set with done and rdata unchanged (busy lasts 21*CLK_DIV cycles); ack_err SHALL clear on the next acknowledged transaction.
REQ-036 Macro I2C_MASTER_ACK_CHECK_EN undefined: the ACK result SHALL be ignored, DATA SHALL always run, and ack_err SHALL be tied to 0.

Verification
REQ-037 Reset, then idle 10 cycles -> scl=1, sda=1, busy=0, done=0, rdata=0x00.
REQ-038 CLK_DIV=4, write addr=0x54, wdata=0xA5, sda_in=1 at ACK -> SDA bit sequence 1010100,0,[ack],10100101; done after 148 cycles; m_stop high for 4 cycles before done.
REQ-039 Read addr=0x54, slave returns 0x3C -> rdata=0x3C with done, ack_err=0.
REQ-040 With ACK check enabled, addr=0x12, sda_in=0 at ACK -> no data bits, STOP, ack_err=1, done after 84 cycles; repeated without the macro -> 148 cycles, ack_err=0.
REQ-041 reset=1 during DATA bit 3 -> next edge scl=1, sda=1, busy=0, m_stop=0, no done pulse.
REQ-042 start held high through a transaction and through the done cycle -> second transaction starts the cycle after done; start pulses while busy are ignored.
